// File: rtl/regfile_pkg.sv
// Shared defaults and dump FSM encoding for the regfile_gen2 register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF   = 4;
    localparam int unsigned BYPASS_DEF   = 1;
    localparam int unsigned ZERO_REG_DEF = 0;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_LOAD = 2'd1,
        DUMP_SEND = 2'd2
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks every register index and presents each word on a valid/ready port.
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic              i_ready,
    input  logic [DATA_W-1:0] i_word,
    output logic              o_busy,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    dump_state_e       r_state;
    logic              r_busy;
    logic              r_valid;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    assign o_busy  = r_busy;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_addr  = r_addr;
    assign o_data  = r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= DUMP_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                DUMP_IDLE: begin
                    if (i_req) begin
                        r_state <= DUMP_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                DUMP_LOAD: begin
                    // i_word is the stored value before this edge, so a same-cycle write is not seen
                    r_data  <= i_word;
                    r_valid <= 1'b1;
                    r_last  <= (r_addr == LAST_ADDR);
                    r_state <= DUMP_SEND;
                end
                DUMP_SEND: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        if (r_last) begin
                            r_state <= DUMP_IDLE;
                            r_busy  <= 1'b0;
                            r_addr  <= '0;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_state <= DUMP_LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= DUMP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/regfile_gen2.sv
// Two-read/one-write register file with byte-masked writes, per-entry valid bits,
// optional write forwarding and hardwired zero register, plus a streaming dump port.
module regfile_gen2
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned BYPASS   = BYPASS_DEF,
    parameter int unsigned ZERO_REG = ZERO_REG_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [ADDR_W-1:0]   Raddr1,
    input  logic [ADDR_W-1:0]   Raddr2,
    output logic [DATA_W-1:0]   Read1,
    output logic [DATA_W-1:0]   Read2,
    input  logic [ADDR_W-1:0]   Waddr,
    input  logic [DATA_W-1:0]   Writedata,
    input  logic [DATA_W/8-1:0] Wmask,
    input  logic                RegWr,
    input  logic                DumpReq,
    output logic                DumpBusy,
    output logic                DumpValid,
    input  logic                DumpReady,
    output logic [ADDR_W-1:0]   DumpAddr,
    output logic [DATA_W-1:0]   DumpData,
    output logic                DumpLast
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;

    logic              w_we;
    logic [DATA_W-1:0] w_wold;
    logic [DATA_W-1:0] w_wmerge;
    logic [DATA_W-1:0] w_dump_word;

    assign w_we = RegWr && !((ZERO_REG != 0) && (Waddr == '0));

    // Unmasked lanes of a never-written entry merge as zero, not stale array contents
    always_comb begin
        w_wold   = r_valid[Waddr] ? r_mem[Waddr] : '0;
        w_wmerge = w_wold;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (Wmask[b]) begin
                w_wmerge[b*8 +: 8] = Writedata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        Read1 = '0;
        if ((ZERO_REG != 0) && (Raddr1 == '0)) begin
            Read1 = '0;
        end else if ((BYPASS != 0) && w_we && (Raddr1 == Waddr)) begin
            Read1 = w_wmerge;
        end else if (r_valid[Raddr1]) begin
            Read1 = r_mem[Raddr1];
        end
    end

    always_comb begin
        Read2 = '0;
        if ((ZERO_REG != 0) && (Raddr2 == '0)) begin
            Read2 = '0;
        end else if ((BYPASS != 0) && w_we && (Raddr2 == Waddr)) begin
            Read2 = w_wmerge;
        end else if (r_valid[Raddr2]) begin
            Read2 = r_mem[Raddr2];
        end
    end

    always_comb begin
        w_dump_word = '0;
        if (!((ZERO_REG != 0) && (DumpAddr == '0)) && r_valid[DumpAddr]) begin
            w_dump_word = r_mem[DumpAddr];
        end
    end

    always_ff @(posedge CLK) begin
        if (w_we) begin
            r_mem[Waddr] <= w_wmerge;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_valid <= '0;
        end else if (w_we) begin
            r_valid[Waddr] <= 1'b1;
        end
    end

    regfile_dump_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dump_ctrl (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_req   (DumpReq),
        .i_ready (DumpReady),
        .i_word  (w_dump_word),
        .o_busy  (DumpBusy),
        .o_valid (DumpValid),
        .o_addr  (DumpAddr),
        .o_data  (DumpData),
        .o_last  (DumpLast)
    );

endmodule
